uart_tx_fifo: RTL and testbench

//   Elastic buffer directly upstream of the UART transmitter. Absorbs byte bursts from the
//   CPU/MMIO side and presents them to the transmitter's data_in/data_in_valid/data_in_ready

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_fifo_mem.sv | 23 ++
 rtl/uart_tx_fifo.sv | 92 +++++++++
 tb/tb_uart_tx_fifo.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: data width, default TX FIFO depth, overflow counter width,
// and the pointer-width helper used by the FIFO.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_OVF_CNT_W  = 8;

    // One extra wrap bit above the index so full and empty can be told apart.
    function automatic int uart_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// FIFO storage array: DEPTH x WIDTH, synchronous write, asynchronous read.
// Contents are intentionally not reset.
module uart_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through elastic buffer in front of the UART transmitter.
// Define UART_TX_FIFO_OVF_EN to add the overflow sticky flag, drop counter and clear input.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enq_valid,
    input  logic [WIDTH-1:0]          enq_data,
    output logic                      enq_ready,
    output logic                      deq_valid,
    output logic [WIDTH-1:0]          deq_data,
    input  logic                      deq_ready,
    output logic                      full,
    output logic                      empty,
`ifdef UART_TX_FIFO_OVF_EN
    output logic                      ovf_sticky,
    output logic [UART_OVF_CNT_W-1:0] ovf_drops,
    input  logic                      ovf_clear,
`endif
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = uart_ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_deq;

    assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Full blocks enqueue even when a dequeue fires the same cycle: no pass-through.
    assign w_enq = enq_valid && !w_full;
    assign w_deq = deq_ready && !w_empty;

    assign enq_ready = !w_full;
    assign deq_valid = !w_empty;
    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_enq),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (enq_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (deq_data)
    );

`ifdef UART_TX_FIFO_OVF_EN
    logic                      r_ovf_sticky;
    logic [UART_OVF_CNT_W-1:0] r_ovf_drops;

    // Clear wins over a same-cycle drop; that drop is not counted.
    always_ff @(posedge clk) begin
        if (reset || ovf_clear) begin
            r_ovf_sticky <= 1'b0;
            r_ovf_drops  <= '0;
        end else if (enq_valid && w_full) begin
            r_ovf_sticky <= 1'b1;
            if (r_ovf_drops != '1) r_ovf_drops <= r_ovf_drops + 1'b1;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
    assign ovf_drops  = r_ovf_drops;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table plus queue-model scoreboard sequences.
// Covers UART_TX_FIFO_OVF_EN when that macro is defined for both bench and RTL.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             enq_valid;
    logic [WIDTH-1:0] enq_data;
    logic             enq_ready;
    logic             deq_valid;
    logic [WIDTH-1:0] deq_data;
    logic             deq_ready;
    logic             full;
    logic             empty;
    logic [4:0]       count;
`ifdef UART_TX_FIFO_OVF_EN
    logic             ovf_sticky;
    logic [7:0]       ovf_drops;
    logic             ovf_clear;
`endif

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .enq_valid  (enq_valid),
        .enq_data   (enq_data),
        .enq_ready  (enq_ready),
        .deq_valid  (deq_valid),
        .deq_data   (deq_data),
        .deq_ready  (deq_ready),
        .full       (full),
        .empty      (empty),
`ifdef UART_TX_FIFO_OVF_EN
        .ovf_sticky (ovf_sticky),
        .ovf_drops  (ovf_drops),
        .ovf_clear  (ovf_clear),
`endif
        .count      (count)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [7:0]    sb_q[$];
    logic          exp_sticky;
    int            exp_drops;

    typedef struct {
        logic       ev;
        logic [7:0] d;
        logic       dr;
        int         e_count;
        logic       e_dv;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare pre-edge outputs against the model, then clock.
    task automatic step(input logic ev, input logic [7:0] d, input logic dr, input logic clr);
        logic       m_full;
        logic [7:0] popped;
        enq_valid = ev;
        enq_data  = d;
        deq_ready = dr;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clear = clr;
`endif
        #1;
        m_full = (sb_q.size() == DEPTH);
        chk("count",     int'(count),     sb_q.size());
        chk("deq_valid", int'(deq_valid), int'(sb_q.size() != 0));
        chk("enq_ready", int'(enq_ready), int'(!m_full));
        chk("full",      int'(full),      int'(m_full));
        chk("empty",     int'(empty),     int'(sb_q.size() == 0));
        if (sb_q.size() != 0 && dr) begin
            popped = sb_q.pop_front();
            chk("deq_data", int'(deq_data), int'(popped));
        end else if (sb_q.size() != 0) begin
            chk("deq_data_hold", int'(deq_data), int'(sb_q[0]));
        end
        if (ev && !m_full) sb_q.push_back(d);
        if (clr) begin
            exp_sticky = 1'b0;
            exp_drops  = 0;
        end else if (ev && m_full) begin
            exp_sticky = 1'b1;
            if (exp_drops < 255) exp_drops++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enq_valid = 1'b0;
        enq_data  = '0;
        deq_ready = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clear = 1'b0;
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        exp_sticky = 1'b0;
        exp_drops  = 0;
    endtask

    task automatic chk_ovf(input string tag);
`ifdef UART_TX_FIFO_OVF_EN
        chk({tag, "_ovf_sticky"}, int'(ovf_sticky), int'(exp_sticky));
        chk({tag, "_ovf_drops"},  int'(ovf_drops),  exp_drops);
`else
        chk({tag, "_qsize"}, int'(count), sb_q.size());
`endif
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h55, 1'b0, 1, 1'b1, 8'h55};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h55};
        vecs[2] = '{1'b1, 8'h12, 1'b1, 1, 1'b1, 8'h12};
        vecs[3] = '{1'b1, 8'h34, 1'b0, 2, 1'b1, 8'h12};
        vecs[4] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h34};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 8'h77, 1'b1, 1, 1'b1, 8'h77};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};

        do_reset();
        // Idle after reset
        @(posedge clk);
        #1;
        chk("rst_empty",     int'(empty),     1);
        chk("rst_full",      int'(full),      0);
        chk("rst_count",     int'(count),     0);
        chk("rst_deq_valid", int'(deq_valid), 0);
        chk("rst_enq_ready", int'(enq_ready), 1);
        chk_ovf("rst");

        // Vector table: single-cycle behaviours incl. empty-dequeue and no bypass
        foreach (vecs[i]) begin
            step(vecs[i].ev, vecs[i].d, vecs[i].dr, 1'b0);
            chk($sformatf("vec%0d_count", i), int'(count), vecs[i].e_count);
            chk($sformatf("vec%0d_dv", i), int'(deq_valid), int'(vecs[i].e_dv));
            if (vecs[i].e_dv) chk($sformatf("vec%0d_data", i), int'(deq_data), int'(vecs[i].e_data));
        end

        // Fill to full
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full",      int'(full),      1);
        chk("fill_count",     int'(count),     16);
        chk("fill_enq_ready", int'(enq_ready), 0);

        // Write while full with dequeue same cycle: byte dropped
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("drop_count", int'(count), 15);
        chk_ovf("drop");
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk_ovf("clr");

`ifdef UART_TX_FIFO_OVF_EN
        // Saturation of the drop counter, then clear beating a same-cycle drop
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("sat_drops", int'(ovf_drops), 255);
        step(1'b1, 8'hBB, 1'b0, 1'b1);
        chk_ovf("clr_pri");
`endif

        // Drain in order
        while (sb_q.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_empty", int'(empty), 1);

        // Half full then steady enq+deq across pointer wrap
        for (int i = 0; i < DEPTH / 2; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
        chk("wrap_count", int'(count), DEPTH / 2);

        // Mid-operation reset discards contents
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        chk("pre_rst_count", int'(count), 5);
        do_reset();
        chk("post_rst_count", int'(count),     0);
        chk("post_rst_dv",    int'(deq_valid), 0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        chk("post_rst_head", int'(deq_data), 8'h33);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_empty", int'(empty), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
